// File: rtl/axi_burst_read_arbiter_if.sv
// AXI read-address and read-data channel bundle shared by the burst read arbiter
// and the downstream slave.
interface axi_burst_read_arbiter_if #(
  parameter int DATA_W = 32
);
  logic [3:0]        arid;
  logic [31:0]       araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic [1:0]        arlock;
  logic [3:0]        arcache;
  logic [2:0]        arprot;
  logic              arvalid;
  logic              arready;

  logic [3:0]        rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi_burst_read_arbiter.sv
// Round-robin arbiter sharing one AXI AR/R port among NCH burst-read clients,
// with one burst outstanding and beat count / ID / response checking.
module axi_burst_read_arbiter #(
  parameter int NCH     = 3,
  parameter int DATA_W  = 32,
  parameter int MAX_LEN = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NCH-1:0]        req,
  input  logic [NCH*32-1:0]     req_addr,
  input  logic [NCH*8-1:0]      req_len,
  output logic [NCH-1:0]        addr_ok,
  output logic [NCH-1:0]        beat_valid,
  output logic [NCH-1:0]        beat_last,
  output logic [DATA_W-1:0]     rdata_o,
  output logic                  err,
  axi_burst_read_arbiter_if.master axi
);

  localparam int         IDX_W   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [2:0] ARSIZE  = 3'($clog2(DATA_W / 8));
  localparam logic [7:0] LEN_CAP = 8'(MAX_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_AR,
    ST_R
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             arvalid_c;
  logic             rready_c;
  logic             ar_fire;
  logic             r_fire;

  logic [IDX_W-1:0] rr;
  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] cand;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_found;
  logic [7:0]       grant_len_raw;
  logic [7:0]       grant_len;
  logic [31:0]      grant_addr;

  logic [31:0]      addr_q;
  logic [7:0]       len_q;
  logic [7:0]       beat_cnt;

  // Round-robin search: first requester at or after the rr pointer wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NCH; k++) begin
      cand = IDX_W'((int'(rr) + k) % NCH);
      if (!grant_found && req[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    grant_addr    = req_addr[{grant_idx, 5'b00000} +: 32];
    grant_len_raw = req_len[{grant_idx, 3'b000} +: 8];
    grant_len     = (grant_len_raw > LEN_CAP) ? LEN_CAP : grant_len_raw;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    arvalid_c = 1'b0;
    rready_c  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (grant_found) begin
          state_nxt = ST_AR;
        end
      end
      ST_AR: begin
        arvalid_c = 1'b1;
        if (axi.arready) begin
          state_nxt = ST_R;
        end
      end
      ST_R: begin
        rready_c = 1'b1;
        // Only rlast ends the burst, even after a length error was flagged.
        if (axi.rvalid && axi.rlast) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign ar_fire = arvalid_c & axi.arready;
  assign r_fire  = rready_c & axi.rvalid;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rr       <= '0;
      winner   <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      beat_cnt <= '0;
    end else begin
      if (state == ST_IDLE && grant_found) begin
        winner <= grant_idx;
        addr_q <= grant_addr;
        len_q  <= grant_len;
      end
      if (ar_fire) begin
        rr       <= (winner == IDX_W'(NCH - 1)) ? '0 : winner + IDX_W'(1);
        beat_cnt <= '0;
      end else if (r_fire) begin
        beat_cnt <= beat_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    addr_ok    = '0;
    beat_valid = '0;
    beat_last  = '0;
    for (int i = 0; i < NCH; i++) begin
      if (winner == IDX_W'(i)) begin
        addr_ok[i]    = ar_fire;
        beat_valid[i] = r_fire;
        beat_last[i]  = r_fire & axi.rlast;
      end
    end
  end

  // Any mismatch between the response and the granted burst pulses err for that beat.
  always_comb begin
    err = r_fire & ((axi.rresp != 2'b00) ||
                    (axi.rid != 4'(winner)) ||
                    (axi.rlast && (beat_cnt != len_q)) ||
                    (!axi.rlast && (beat_cnt == len_q)));
  end

  assign rdata_o     = axi.rdata;
  assign axi.rready  = rready_c;
  assign axi.arvalid = arvalid_c;
  assign axi.arid    = 4'(winner);
  assign axi.araddr  = addr_q;
  assign axi.arlen   = len_q;
  assign axi.arsize  = ARSIZE;
  assign axi.arburst = 2'b01;
  assign axi.arlock  = 2'b00;
  assign axi.arcache = 4'b0000;
  assign axi.arprot  = 3'b000;

endmodule

// File: tb/tb_axi_burst_read_arbiter.sv
// Scoreboard bench for axi_burst_read_arbiter: directed bursts push expected AR and
// R-beat results into queues that a negedge monitor pops and compares.
module tb_axi_burst_read_arbiter;

  localparam int NCH     = 3;
  localparam int DATA_W  = 32;
  localparam int MAX_LEN = 16;

  logic                 clk = 1'b0;
  logic                 resetn;
  logic [NCH-1:0]       req;
  logic [NCH*32-1:0]    req_addr;
  logic [NCH*8-1:0]     req_len;
  logic [NCH-1:0]       addr_ok;
  logic [NCH-1:0]       beat_valid;
  logic [NCH-1:0]       beat_last;
  logic [DATA_W-1:0]    rdata_o;
  logic                 err;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  typedef struct {
    int          client;
    logic [31:0] addr;
    logic [7:0]  len;
  } ar_t;

  typedef struct {
    int          client;
    logic [31:0] data;
    logic        last;
    logic        err;
  } beat_t;

  ar_t   exp_ar[$];
  beat_t exp_beats[$];
  int    hs_cycle[$];

  axi_burst_read_arbiter_if #(.DATA_W(DATA_W)) axi();

  axi_burst_read_arbiter #(
    .NCH     (NCH),
    .DATA_W  (DATA_W),
    .MAX_LEN (MAX_LEN)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .req        (req),
    .req_addr   (req_addr),
    .req_len    (req_len),
    .addr_ok    (addr_ok),
    .beat_valid (beat_valid),
    .beat_last  (beat_last),
    .rdata_o    (rdata_o),
    .err        (err),
    .axi        (axi)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h at cycle %0d", name, actual, expected, cycle);
    end
  endtask

  task automatic applyStimulus(input logic [NCH-1:0] mask);
    req = mask;
  endtask

  task automatic set_client(input int c, input logic [31:0] addr, input logic [7:0] len);
    req_addr[c*32 +: 32] = addr;
    req_len[c*8 +: 8]    = len;
  endtask

  task automatic push_ar(input int c, input logic [31:0] addr, input logic [7:0] len);
    ar_t a;
    a.client = c;
    a.addr   = addr;
    a.len    = len;
    exp_ar.push_back(a);
  endtask

  // Waits for arvalid, keeps arready low for wait_cycles, then accepts.
  task automatic ar_accept(input int wait_cycles);
    int guard = 0;
    while (axi.arvalid !== 1'b1 && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 20) begin
      checks++;
      errors++;
      $display("[TB] FAIL ar_timeout arvalid=%0b required=1", axi.arvalid);
      return;
    end
    for (int i = 0; i < wait_cycles; i++) begin
      @(posedge clk); #1;
      checkOutput("arvalid_hold", 64'(axi.arvalid), 64'd1);
    end
    axi.arready = 1'b1;
    @(posedge clk); #1;
    axi.arready = 1'b0;
    checkOutput("arvalid_drop", 64'(axi.arvalid), 64'd0);
  endtask

  task automatic send_beat(input int client, input logic [3:0] id, input logic [31:0] data,
                           input logic [1:0] resp, input logic last, input logic exp_err);
    int    guard = 0;
    beat_t b;
    axi.rvalid = 1'b1;
    axi.rid    = id;
    axi.rdata  = data;
    axi.rresp  = resp;
    axi.rlast  = last;
    while (axi.rready !== 1'b1 && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 20) begin
      checks++;
      errors++;
      $display("[TB] FAIL r_timeout rready=%0b required=1", axi.rready);
      axi.rvalid = 1'b0;
      return;
    end
    b.client = client;
    b.data   = data;
    b.last   = last;
    b.err    = exp_err;
    exp_beats.push_back(b);
    @(posedge clk); #1;
    axi.rvalid = 1'b0;
    axi.rlast  = 1'b0;
    axi.rresp  = 2'b00;
  endtask

  task automatic normal_burst(input int client, input int nbeats, input logic [31:0] base);
    for (int i = 0; i < nbeats; i++) begin
      send_beat(client, 4'(client), base + 32'(i), 2'b00, (i == nbeats - 1), 1'b0);
    end
  endtask

  // Monitor: every AR handshake and every forwarded beat is matched to the scoreboard.
  always @(negedge clk) begin
    ar_t   a;
    beat_t b;
    if (axi.arvalid && axi.arready) begin
      hs_cycle.push_back(cycle);
      if (exp_ar.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL ar_unexpected arid=%0d required=none", axi.arid);
      end else begin
        a = exp_ar.pop_front();
        checkOutput("arid", 64'(axi.arid), 64'(a.client));
        checkOutput("araddr", 64'(axi.araddr), 64'(a.addr));
        checkOutput("arlen", 64'(axi.arlen), 64'(a.len));
        checkOutput("addr_ok", 64'(addr_ok), 64'd1 << a.client);
        checkOutput("arsize", 64'(axi.arsize), 64'd2);
        checkOutput("arburst", 64'(axi.arburst), 64'd1);
        checkOutput("ar_const", 64'({axi.arlock, axi.arcache, axi.arprot}), 64'd0);
      end
    end else if (addr_ok != '0) begin
      checks++;
      errors++;
      $display("[TB] FAIL addr_ok_spurious actual=0x%0h required=0", addr_ok);
    end

    if (beat_valid != '0 || err) begin
      if (exp_beats.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL beat_unexpected beat_valid=0x%0h err=%0b required=none", beat_valid, err);
      end else begin
        b = exp_beats.pop_front();
        checkOutput("beat_valid", 64'(beat_valid), 64'd1 << b.client);
        checkOutput("beat_last", 64'(beat_last), b.last ? (64'd1 << b.client) : 64'd0);
        checkOutput("rdata_o", 64'(rdata_o), 64'(b.data));
        checkOutput("err", 64'(err), 64'(b.err));
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    resetn      = 1'b0;
    req         = '0;
    req_addr    = '0;
    req_len     = '0;
    axi.arready = 1'b0;
    axi.rvalid  = 1'b0;
    axi.rid     = 4'd0;
    axi.rdata   = 32'hCAFE_F00D;
    axi.rresp   = 2'b00;
    axi.rlast   = 1'b0;

    #3;
    $display("[TB] reset state");
    checkOutput("rst_arvalid", 64'(axi.arvalid), 64'd0);
    checkOutput("rst_rready", 64'(axi.rready), 64'd0);
    checkOutput("rst_addr_ok", 64'(addr_ok), 64'd0);
    checkOutput("rst_beat_valid", 64'(beat_valid), 64'd0);
    checkOutput("rst_beat_last", 64'(beat_last), 64'd0);
    checkOutput("rst_err", 64'(err), 64'd0);
    checkOutput("rst_ar_fields", 64'({axi.arid, axi.araddr, axi.arlen}), 64'd0);
    checkOutput("rst_arsize", 64'(axi.arsize), 64'd2);
    checkOutput("rst_arburst", 64'(axi.arburst), 64'd1);
    checkOutput("rst_rdata_pass", 64'(rdata_o), 64'h0000_0000_CAFE_F00D);
    @(posedge clk); #1;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;

    $display("[TB] round-robin, three clients, len 3, zero-wait");
    for (int c = 0; c < NCH; c++) set_client(c, 32'h1000_0000 + 32'(c) * 32'h100, 8'd3);
    for (int k = 0; k < 6; k++) push_ar(k % 3, 32'h1000_0000 + 32'(k % 3) * 32'h100, 8'd3);
    applyStimulus(3'b111);
    for (int k = 0; k < 6; k++) begin
      ar_accept(0);
      if (k == 5) applyStimulus(3'b000);
      normal_burst(k % 3, 4, 32'hA000_0000 + 32'(k) * 32'h10);
    end
    checkOutput("hs_count", 64'(hs_cycle.size()), 64'd6);
    if (hs_cycle.size() >= 6) begin
      for (int k = 0; k < 5; k++) checkOutput("burst_spacing", 64'(hs_cycle[k+1] - hs_cycle[k]), 64'd6);
    end

    $display("[TB] single request, arready delayed 3 cycles");
    set_client(0, 32'h1FC0_0000, 8'd7);
    push_ar(0, 32'h1FC0_0000, 8'd7);
    applyStimulus(3'b001);
    ar_accept(3);
    applyStimulus(3'b000);
    normal_burst(0, 8, 32'hD000_0000);

    $display("[TB] early rlast on beat 2 of len 3");
    set_client(2, 32'h3000_0000, 8'd3);
    push_ar(2, 32'h3000_0000, 8'd3);
    applyStimulus(3'b100);
    ar_accept(1);
    applyStimulus(3'b000);
    send_beat(2, 4'd2, 32'h3333_0000, 2'b00, 1'b0, 1'b0);
    send_beat(2, 4'd2, 32'h3333_0001, 2'b00, 1'b0, 1'b0);
    send_beat(2, 4'd2, 32'h3333_0002, 2'b00, 1'b1, 1'b1);

    $display("[TB] rresp error on beat 1");
    set_client(0, 32'h0400_0040, 8'd3);
    push_ar(0, 32'h0400_0040, 8'd3);
    applyStimulus(3'b001);
    ar_accept(0);
    applyStimulus(3'b000);
    send_beat(0, 4'd0, 32'h4444_0000, 2'b00, 1'b0, 1'b0);
    send_beat(0, 4'd0, 32'h4444_0001, 2'b10, 1'b0, 1'b1);
    send_beat(0, 4'd0, 32'h4444_0002, 2'b00, 1'b0, 1'b0);
    send_beat(0, 4'd0, 32'h4444_0003, 2'b00, 1'b1, 1'b0);

    $display("[TB] wrong rid while client 1 granted");
    set_client(1, 32'h0500_0000, 8'd1);
    push_ar(1, 32'h0500_0000, 8'd1);
    applyStimulus(3'b010);
    ar_accept(0);
    applyStimulus(3'b000);
    send_beat(1, 4'd2, 32'h5555_0000, 2'b00, 1'b0, 1'b1);
    send_beat(1, 4'd1, 32'h5555_0001, 2'b00, 1'b1, 1'b0);

    $display("[TB] missing rlast at final count");
    set_client(2, 32'h0600_0000, 8'd1);
    push_ar(2, 32'h0600_0000, 8'd1);
    applyStimulus(3'b100);
    ar_accept(0);
    applyStimulus(3'b000);
    send_beat(2, 4'd2, 32'h6666_0000, 2'b00, 1'b0, 1'b0);
    send_beat(2, 4'd2, 32'h6666_0001, 2'b00, 1'b0, 1'b1);
    send_beat(2, 4'd2, 32'h6666_0002, 2'b00, 1'b1, 1'b1);

    $display("[TB] req_len 0xFF clipped to 15");
    set_client(1, 32'h0700_0000, 8'hFF);
    push_ar(1, 32'h0700_0000, 8'd15);
    applyStimulus(3'b010);
    ar_accept(0);
    applyStimulus(3'b000);
    normal_burst(1, 16, 32'h7777_0000);

    $display("[TB] reset during beat 2");
    set_client(1, 32'h0800_0000, 8'd3);
    push_ar(1, 32'h0800_0000, 8'd3);
    applyStimulus(3'b010);
    ar_accept(0);
    send_beat(1, 4'd1, 32'h8888_0000, 2'b00, 1'b0, 1'b0);
    send_beat(1, 4'd1, 32'h8888_0001, 2'b00, 1'b0, 1'b0);
    axi.rvalid = 1'b1;
    axi.rid    = 4'd1;
    axi.rdata  = 32'h8888_0002;
    #1;
    checkOutput("bv_before_rst", 64'(beat_valid), 64'd2);
    resetn = 1'b0;
    applyStimulus(3'b000);
    #1;
    checkOutput("async_rready", 64'(axi.rready), 64'd0);
    checkOutput("async_beat_valid", 64'(beat_valid), 64'd0);
    checkOutput("async_arvalid", 64'(axi.arvalid), 64'd0);
    checkOutput("async_err", 64'(err), 64'd0);
    checkOutput("async_ar_fields", 64'({axi.arid, axi.araddr, axi.arlen}), 64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    resetn = 1'b1;
    axi.rlast = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checkOutput("stray_rready", 64'(axi.rready), 64'd0);
      checkOutput("stray_beat_valid", 64'(beat_valid), 64'd0);
    end

    $display("[TB] pointer back at 0 after reset");
    for (int c = 0; c < NCH; c++) set_client(c, 32'h0900_0000 + 32'(c) * 32'h40, 8'd0);
    push_ar(0, 32'h0900_0000, 8'd0);
    push_ar(1, 32'h0900_0040, 8'd0);
    push_ar(2, 32'h0900_0080, 8'd0);
    applyStimulus(3'b111);
    ar_accept(0);
    applyStimulus(3'b110);
    send_beat(0, 4'd0, 32'h9999_0000, 2'b00, 1'b1, 1'b0);
    ar_accept(0);
    applyStimulus(3'b100);
    send_beat(1, 4'd1, 32'h9999_0001, 2'b00, 1'b1, 1'b0);
    ar_accept(0);
    applyStimulus(3'b000);
    send_beat(2, 4'd2, 32'h9999_0002, 2'b00, 1'b1, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("ar_queue_drained", 64'(exp_ar.size()), 64'd0);
    checkOutput("beat_queue_drained", 64'(exp_beats.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_burst_read_arbiter.md
# axi_burst_read_arbiter

Parametrised AXI read-channel arbiter that shares one AR/R port among `NCH` burst-read clients: I$ refill, D$ refill, and the uncached path. It generalises the single-client cache read interface to a configurable number of channels, a per-request burst length, round-robin fairness and burst-length/ID checking. It sits between the MMU-side clients and the top-level AXI read channel. Only one burst is outstanding at a time.

## Interface
Parameters:
- `NCH`, 3, number of client channels (2..8); client i has AXI ID i.
- `DATA_W`, 32, R data width; `arsize` = log2(`DATA_W`/8).
- `MAX_LEN`, 16, largest legal burst in beats; `len` values above `MAX_LEN`-1 are clipped to `MAX_LEN`-1.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk`  in  1  clock.
- `resetn`  in  1  asynchronous active-low reset.
- `req`  in  NCH  per-client burst request; held until that client's `addr_ok`.
- `req_addr`  in  NCH*32  client i start address in bits [32i+31:32i]; held with `req`.
- `req_len`  in  NCH*8  client i beats-minus-one; held with `req`.
- `addr_ok`  out  NCH  one-hot pulse when client i's AR is accepted.
- `beat_valid`  out  NCH  one-hot; `rdata_o` is valid for client i this cycle.
- `beat_last`  out  NCH  one-hot; last beat for client i.
- `rdata_o`  out  DATA_W  broadcast read data.
- `err`  out  1  one-cycle pulse on a protocol or response error.
- AR port: `arid`[3:0], `araddr`[31:0], `arlen`[7:0], `arsize`[2:0], `arburst`[1:0], `arlock`[1:0], `arcache`[3:0], `arprot`[2:0], `arvalid` (all out); `arready` in.
- R port: `rid`[3:0], `rdata`[DATA_W-1:0], `rresp`[1:0], `rlast`, `rvalid` (all in); `rready` out.

## Operation
- FSM states:
  - IDLE → AR when any `req` is set. Arbitration: round-robin starting at pointer `rr`. The winner index, address and clipped length are registered.
  - AR → R on `arvalid & arready`. At that point `rr` ← (winner+1) mod `NCH`.
  - R → IDLE on an accepted beat with `rlast`=1.
- Constants: `arburst`=2'b01 (INCR), `arlock`=0, `arcache`=0, `arprot`=0.
- `arid`=winner, `araddr`=latched address, `arlen`=latched length; all held stable while `arvalid`.
- `rready`=1 only in R.
- A beat is accepted when `rvalid & rready`.
  - `beat_valid`[winner]=1 and `rdata_o`=`rdata`, combinationally.
  - `beat_last`[winner]=`rlast`.
- Beat counter: 8 bits, cleared on AR acceptance, incremented per accepted beat.
- `err` pulses on any of the following:
  - `rresp`≠0 on an accepted beat;
  - `rid`≠winner;
  - `rlast`=1 while counter≠latched length;
  - counter==latched length with `rlast`=0.
- After an error the beat is still forwarded. The FSM leaves R only on `rlast`.
- Clients not granted see no pulses. Deasserting `req` before `addr_ok` is illegal and not checked.

## Timing
- Reset (async, immediate): state IDLE, `rr`=0, counter=0. `arvalid`=0, `rready`=0, `addr_ok`=0, `beat_valid`=0, `beat_last`=0, `err`=0, `arid`/`araddr`/`arlen`=0, `rdata_o`=`rdata` (passthrough), `arsize`/`arburst` at their constants.
- Reset mid-burst: everything drops in the same cycle. Outstanding R beats arriving after reset release are not accepted (`rready`=0 in IDLE).
- Latencies:
  - `req` sampled in IDLE at edge N → `arvalid`=1 from cycle N+1.
  - `addr_ok` is combinational in the cycle of `arvalid & arready`, so minimum 1 cycle from `req` to `addr_ok`.
  - Beat forwarding is 0-cycle combinational.
- One IDLE bubble follows each burst. Back-to-back bursts therefore need at least 2 cycles of AR overhead.
- Simultaneous requests are resolved by `rr` alone. A request arriving during an AR or R phase waits for IDLE.
- `arvalid` is never withdrawn before `arready`, per AXI.

## Test plan
- Single request: client 0 requests 0x1FC0_0000 with len 7, `arready` is held low for 3 cycles, then 8 beats D0..D7 arrive with `rlast` on beat 7.
  - `arvalid` is held for 4 cycles with `arid`=0 and `arlen`=7.
  - `addr_ok`[0] is a single pulse.
  - `beat_valid`[0] asserts 8 times and `beat_last`[0] asserts on D7.
  - `err` stays 0.
- All 3 clients request continuously with len 3 and zero-wait slaves. Grants occur in the order 0,1,2,0,1,2. Each burst occupies 1 IDLE + 1 AR + 4 R cycles.
- Early `rlast` on beat 2 of a len-3 burst: `err` pulses once, FSM returns to IDLE, and the next request is granted.
- Response faults:
  - `rresp`=2'b10 on beat 1 → `err` pulse; the beat is still forwarded.
  - `rid`=2 while client 1 is granted → `err` pulse.
- `resetn` is dropped during beat 2 of a burst:
  - `rready`, `beat_valid` and `arvalid` go to 0 asynchronously.
  - After release, `rr`=0, and stray `rvalid` is ignored until a new AR is issued.
- `req_len`=0xFF with `MAX_LEN`=16: `arlen`=15, and `beat_last` asserts on beat 16.
